// File: rtl/ser_tx_pkg.sv
// ser_tx_pkg: shared FSM encoding, frame constants and output bit map for the serial transmitter.
package ser_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int unsigned DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int TX_BIT = 0;
  localparam int BUSY_BIT = 1;
  localparam int READY_BIT = 2;
  localparam int FULL_BIT = 3;
endpackage

// File: rtl/ser_baud_tick.sv
// ser_baud_tick: one-cycle tick every CLKS_PER_BIT enabled cycles; clear parks the count at zero.
module ser_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clear,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  logic [7:0] cnt;
  assign tick = ena && cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst_n) cnt <= '0;
    else if (ena) cnt <= (clear || tick) ? '0 : cnt + 8'd1;
  end
endmodule

// File: rtl/tt_um_ser_tx.sv
// tt_um_ser_tx: UART-style serial transmitter with a one-entry holding register and optional even parity.
module tt_um_ser_tx
  import ser_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  state_t state, state_nx;
  logic [2:0] bit_cnt;
  logic [7:0] shift, hold_data;
  logic hold_par, hold_full, par_en, par_bit;
  logic tick, load, step, accept, tx, busy;
  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:2]};
  ser_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(state == IDLE), .tick(tick)
  );
  // accept needs hold_full=0 and load needs hold_full=1, so they never coincide
  assign accept = ena && uio_in[0] && !hold_full;
  always_comb begin
    state_nx = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: if (ena && hold_full) begin
        state_nx = START;
        load = 1'b1;
      end
      START: if (tick) state_nx = DATA;
      DATA: if (tick) begin
        step = 1'b1;
        if (bit_cnt == 3'(DATA_BITS - 1)) state_nx = par_en ? PARITY : STOP;
      end
      PARITY: if (tick) state_nx = STOP;
      STOP: if (tick) begin
        state_nx = hold_full ? START : IDLE;
        load = hold_full;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      hold_data <= '0;
      hold_par <= 1'b0;
      hold_full <= 1'b0;
      par_en <= 1'b0;
      par_bit <= 1'b0;
    end else if (ena) begin
      state <= state_nx;
      hold_full <= accept ? 1'b1 : load ? 1'b0 : hold_full;
      if (accept) begin
        hold_data <= ui_in;
        hold_par <= uio_in[1];
      end
      if (load) begin
        shift <= hold_data;
        par_en <= hold_par;
        par_bit <= ^hold_data;
        bit_cnt <= '0;
      end else if (step) begin
        shift <= shift >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end
  assign busy = state != IDLE;
  assign tx = (state == IDLE || state == STOP) ? STOP_BIT :
              state == START ? START_BIT :
              state == DATA ? shift[0] : par_bit;
  always_comb begin
    uo_out = '0;
    uo_out[TX_BIT] = tx;
    uo_out[BUSY_BIT] = busy;
    uo_out[READY_BIT] = !hold_full;
    uo_out[FULL_BIT] = hold_full;
  end
  assign uio_out = '0;
  assign uio_oe = '0;
endmodule

// File: tb/tb_tt_um_ser_tx.sv
// tb_tt_um_ser_tx: frame tables, multi-cycle corner sequences and random traffic against a waveform-queue model.
module tb_tt_um_ser_tx;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int vectors = 0;
  int miscompares = 0;
  bit chk = 1'b0;
  always #5 clk = ~clk;
  tt_um_ser_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  wire tx = uo_out[0];
  wire busy = uo_out[1];
  wire ready = uo_out[2];
  wire hfull = uo_out[3];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // reference: expected tx level for every remaining enabled cycle of the current frame
  bit wave[$];
  bit m_hf = 1'b0;
  bit m_acc, m_hf0;
  logic [7:0] m_data = '0;
  bit m_par = 1'b0;
  function automatic void push_frame(logic [7:0] d, bit p);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (p) bits.push_back(^d);
    bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < CPB; c++) wave.push_back(bits[i]);
  endfunction
  always @(posedge clk) begin
    if (rst_n) begin
      wave.delete();
      m_hf = 1'b0;
    end else if (ena) begin
      m_hf0 = m_hf;
      m_acc = uio_in[0] && !m_hf0;
      if (wave.size() > 0) void'(wave.pop_front());
      if (wave.size() == 0 && m_hf0) begin
        push_frame(m_data, m_par);
        m_hf = 1'b0;
      end
      if (m_acc) begin
        m_hf = 1'b1;
        m_data = ui_in;
        m_par = uio_in[1];
      end
    end
  end
  always @(negedge clk) begin
    if (chk) check("model_uo_out", {24'b0, uo_out},
                   {28'b0, m_hf, !m_hf, wave.size() > 0, wave.size() > 0 ? wave[0] : 1'b1});
  end
  typedef struct {
    logic [7:0] data;
    logic par;
    int len;
    logic [10:0] seq;
  } vec_t;
  vec_t tbl[5];
  task automatic send(input logic [7:0] d, input logic p);
    ui_in = d;
    uio_in = {6'b0, p, 1'b1};
    tick();
    uio_in = '0;
  endtask
  task automatic run_until_idle(input int start, output int n);
    n = start;
    while (busy === 1'b1 && n < start + 300) begin
      n++;
      tick();
    end
  endtask
  int n;
  initial begin
    tbl[0] = '{8'hA5, 1'b0, 10, 11'b0_0101001011};
    tbl[1] = '{8'h07, 1'b1, 11, 11'b01110000011};
    tbl[2] = '{8'h03, 1'b1, 11, 11'b01100000001};
    tbl[3] = '{8'hFF, 1'b1, 11, 11'b01111111101};
    tbl[4] = '{8'h00, 1'b0, 10, 11'b0_0000000001};
    tick();
    tick();
    rst_n = 1'b0;
    chk = 1'b1;
    check("reset_uo_out", {24'b0, uo_out}, 32'h05);
    check("reset_uio_oe", {24'b0, uio_oe}, 32'h0);
    check("reset_uio_out", {24'b0, uio_out}, 32'h0);
    tick();
    foreach (tbl[t]) begin
      send(tbl[t].data, tbl[t].par);
      check("accept_full_ready", {30'b0, hfull, ready}, 32'b10);
      tick();
      for (int k = 0; k < tbl[t].len * CPB; k++) begin
        check("frame_busy_tx", {30'b0, busy, tx}, {30'b0, 1'b1, tbl[t].seq[tbl[t].len - 1 - k / CPB]});
        tick();
      end
      check("frame_end_busy_tx", {30'b0, busy, tx}, 32'b01);
      tick();
    end
    // back-to-back: second byte held mid-frame, no idle gap
    send(8'h00, 1'b0);
    tick();
    repeat (10) tick();
    send(8'hFF, 1'b0);
    check("b2b_held_ready", {30'b0, hfull, ready}, 32'b10);
    repeat (28) tick();
    check("b2b_stop1_ready_tx", {30'b0, ready, tx}, 32'b01);
    tick();
    check("b2b_start2_ready_busy_tx", {29'b0, ready, busy, tx}, 32'b110);
    run_until_idle(40, n);
    check("b2b_busy_cycles", n, 80);
    tick();
    // stall during data bit 2 of 0xA5 (bit value 1)
    send(8'hA5, 1'b0);
    tick();
    repeat (13) tick();
    ena = 1'b0;
    ui_in = 8'h55;
    uio_in = 8'h01;
    for (int k = 0; k < 10; k++) begin
      check("stall_tx_ready_full", {29'b0, tx, ready, hfull}, 32'b110);
      tick();
    end
    ena = 1'b1;
    uio_in = '0;
    run_until_idle(23, n);
    check("stall_busy_cycles", n, 50);
    check("stall_nothing_held", {31'b0, hfull}, 32'b0);
    tick();
    // reset during data bit 3 with a byte held
    send(8'h3C, 1'b0);
    tick();
    send(8'h81, 1'b1);
    repeat (16) tick();
    check("midrst_held", {31'b0, hfull}, 32'b1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("midrst_after", {24'b0, uo_out}, 32'h05);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (busy !== 1'b0) n++;
      tick();
    end
    check("midrst_no_frame", n, 0);
    for (int k = 0; k < 4000; k++) begin
      ena = $urandom_range(0, 9) != 0;
      rst_n = $urandom_range(0, 599) == 0;
      ui_in = 8'($urandom);
      uio_in = {6'($urandom), 1'($urandom), $urandom_range(0, 5) == 0};
      tick();
    end
    rst_n = 1'b0;
    ena = 1'b1;
    uio_in = '0;
    repeat (120) tick();
    check("drain_idle", {24'b0, uo_out}, 32'h05);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tt_um_ser_tx.md
TT_UM_SER_TX -- requirements
Module: tt_um_ser_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit period (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous, active-high reset (asserted = 1 despite the pin name).
REQ-004 SHALL have port: ena  input  1  global enable; 0 freezes all state.
REQ-005 SHALL have port: ui_in  input  8  data byte, driven by the universal register's parallel Q output.
REQ-006 SHALL have port: uio_in  input  8  [0] valid, [1] parity enable (even parity), [7:2] ignored.
REQ-007 SHALL have port: uo_out  output  8  [0] tx, [1] busy, [2] ready, [3] hold_full, [7:4] constant 0.
REQ-008 SHALL have port: uio_out  output  8  constant 0.
REQ-009 SHALL have port: uio_oe  output  8  constant 0 (all uio pins are inputs).

Function
REQ-010 SHALL accept a byte at a rising edge when ena=1, valid=1 and ready=1, capturing ui_in and parity enable into a one-entry holding register.
REQ-011 SHALL drive ready = NOT hold_full, registered; valid while ready=0 is ignored and nothing is captured.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on the edge after hold_full becomes 1, moving the holding register into the shift register and clearing hold_full.
REQ-013 SHALL emit the frame: start bit 0, 8 data bits LSB first, a parity bit only if captured parity enable = 1 (even: XOR of the 8 data bits), stop bit 1.
REQ-014 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles with ena=1; frame length is 10 or 11 bit periods.
REQ-015 SHALL drive tx=1 in IDLE and busy=1 in every state except IDLE.
REQ-016 SHALL, in the last cycle of STOP, go directly to START when hold_full=1 (no idle gap between frames); otherwise go to IDLE.
REQ-017 SHALL register latency: accept at edge N -> hold_full=1 after edge N; tx=0 (start) after edge N+1 when previously IDLE.
REQ-018 SHALL, with ena=0, freeze the FSM, bit counter, baud counter, holding register and outputs, and accept nothing.
REQ-019 SHALL allow a new byte to be accepted in the same cycle that the holding register transfers to the shifter only via the next cycle's ready=1; accept and transfer never coincide.

Reset
REQ-020 SHALL, on rst_n=1 at a rising edge (regardless of ena), set FSM=IDLE, counters=0, hold_full=0, shift and holding data=0; outputs after that edge: tx=1, busy=0, ready=1, hold_full=0.
REQ-021 SHALL abort a frame in progress when reset mid-frame; the pending held byte is discarded and tx=1 is driven from the next cycle.

Structure
REQ-022 SHALL place FSM state encodings, frame constants (data bits = 8, start = 0, stop = 1) and uo_out bit indices in shared package ser_tx_pkg.
REQ-023 SHALL implement the bit-period counter as sub-module ser_baud_tick (inputs clk, rst_n, ena, clear; output one-cycle tick every CLKS_PER_BIT enabled cycles).

Verification (CLKS_PER_BIT=4)
REQ-024 SHALL cover reset: after rst_n pulse -> tx=1, busy=0, ready=1, uo_out[7:4]=0, uio_oe=0.
REQ-025 SHALL cover single byte: send 0xA5 with parity off -> tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; busy high for exactly 40 cycles.
REQ-026 SHALL cover parity: send 0x07 with parity on -> parity bit 1 and 44-cycle frame; send 0x03 -> parity bit 0.
REQ-027 SHALL cover back-to-back: 0x00, then 0xFF accepted mid-frame -> ready=0 until transfer, stop of frame 1 followed immediately by start of frame 2, 80 busy cycles total.
REQ-028 SHALL cover stall: ena=0 for 10 cycles during data bit 2 -> frame lengthens by 10 cycles, bit values unchanged, valid ignored.
REQ-029 SHALL cover mid-frame reset: rst_n during data bit 3 with a byte held -> tx=1, ready=1, hold_full=0 next cycle, no further frame.
